// File: rtl/raster_pkg.sv
// Shared rasterizer types: scan sequencer states, framebuffer coordinate widths
// and the signed bounding-box record used by the bbox generator and scan controller.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLAMP = 2'd1,
      SCAN  = 2'd2,
      FIN   = 2'd3
   } scan_state_e;

   function automatic int hcw(input int hres);
      return $clog2(hres);
   endfunction

   function automatic int vcw(input int vres);
      return $clog2(vres);
   endfunction

   localparam int FB_HRES_DEF = 320;
   localparam int FB_VRES_DEF = 180;
   localparam int HCW         = hcw(FB_HRES_DEF);
   localparam int VCW         = vcw(FB_VRES_DEF);
   localparam int BBOX_CW     = 12;

   typedef struct packed {
      logic signed [BBOX_CW-1:0] xmin;
      logic signed [BBOX_CW-1:0] xmax;
      logic signed [BBOX_CW-1:0] ymin;
      logic signed [BBOX_CW-1:0] ymax;
   } bbox_t;

endpackage

// File: rtl/bbox_scan_ctrl_if.sv
// Bbox-in / pixel-out bus of the scan controller; master is the rasterizer side,
// slave is the controller.
interface bbox_scan_ctrl_if #(
   parameter int FB_HRES = 320,
   parameter int FB_VRES = 180,
   parameter int CW      = 12
);
   localparam int HW = raster_pkg::hcw(FB_HRES);
   localparam int VW = raster_pkg::vcw(FB_VRES);

   logic                 valid_in;
   logic                 ready_out;
   logic signed [CW-1:0] xmin;
   logic signed [CW-1:0] xmax;
   logic signed [CW-1:0] ymin;
   logic signed [CW-1:0] ymax;
   logic                 flush_in;
   logic                 ready_in;
   logic                 valid_out;
   logic [HW-1:0]        hcount;
   logic [VW-1:0]        vcount;
   logic                 last_out;
   logic                 done_out;

   modport master (
      output valid_in, xmin, xmax, ymin, ymax, flush_in, ready_in,
      input  ready_out, valid_out, hcount, vcount, last_out, done_out
   );

   modport slave (
      input  valid_in, xmin, xmax, ymin, ymax, flush_in, ready_in,
      output ready_out, valid_out, hcount, vcount, last_out, done_out
   );

endinterface

// File: rtl/bbox_clamp.sv
// Combinational clamp of a signed bbox to the framebuffer, with empty detection
// covering off-screen and inverted boxes.
module bbox_clamp #(
   parameter int FB_HRES = 320,
   parameter int FB_VRES = 180,
   parameter int CW      = 12,
   parameter int HW      = 9,
   parameter int VW      = 8
) (
   input  logic signed [CW-1:0] xmin,
   input  logic signed [CW-1:0] xmax,
   input  logic signed [CW-1:0] ymin,
   input  logic signed [CW-1:0] ymax,
   output logic [HW-1:0]        cxmin,
   output logic [HW-1:0]        cxmax,
   output logic [VW-1:0]        cymin,
   output logic [VW-1:0]        cymax,
   output logic                 empty
);
   localparam logic signed [CW-1:0] HMAX = CW'(FB_HRES - 1);
   localparam logic signed [CW-1:0] VMAX = CW'(FB_VRES - 1);

   logic signed [CW-1:0] x_lo, x_hi, y_lo, y_hi;

   // Empty is decided on the full signed values, before truncation to pixel width.
   always_comb begin
      x_lo  = xmin[CW-1] ? '0 : xmin;
      x_hi  = (xmax > HMAX) ? HMAX : xmax;
      y_lo  = ymin[CW-1] ? '0 : ymin;
      y_hi  = (ymax > VMAX) ? VMAX : ymax;
      empty = (x_lo > x_hi) || (y_lo > y_hi);
      cxmin = HW'(x_lo);
      cxmax = HW'(x_hi);
      cymin = VW'(y_lo);
      cymax = VW'(y_hi);
   end

endmodule

// File: rtl/bbox_scan_ctrl.sv
// Rasterize-phase sequencer: accepts a bbox, clamps it to the framebuffer and walks
// every covered pixel in raster order under valid/ready backpressure.
module bbox_scan_ctrl
   import raster_pkg::*;
#(
   parameter int FB_HRES = 320,
   parameter int FB_VRES = 180,
   parameter int CW      = 12
) (
   input logic             clk_in,
   input logic             rst_in,
   bbox_scan_ctrl_if.slave bus
);
   localparam int HW = hcw(FB_HRES);
   localparam int VW = vcw(FB_VRES);

   scan_state_e          state_q, state_d;
   logic signed [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic signed [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic [HW-1:0]        cxmin_q, cxmin_d, cxmax_q, cxmax_d, hcount_q, hcount_d;
   logic [VW-1:0]        cymax_q, cymax_d, vcount_q, vcount_d;

   logic [HW-1:0] cl_xmin, cl_xmax;
   logic [VW-1:0] cl_ymin, cl_ymax;
   logic          cl_empty;
   logic          at_last;

   bbox_clamp #(
      .FB_HRES(FB_HRES), .FB_VRES(FB_VRES), .CW(CW), .HW(HW), .VW(VW)
   ) u_clamp (
      .xmin (xmin_q),
      .xmax (xmax_q),
      .ymin (ymin_q),
      .ymax (ymax_q),
      .cxmin(cl_xmin),
      .cxmax(cl_xmax),
      .cymin(cl_ymin),
      .cymax(cl_ymax),
      .empty(cl_empty)
   );

   assign at_last = (hcount_q == cxmax_q) && (vcount_q == cymax_q);

   always_comb begin
      state_d  = state_q;
      xmin_d   = xmin_q;
      xmax_d   = xmax_q;
      ymin_d   = ymin_q;
      ymax_d   = ymax_q;
      cxmin_d  = cxmin_q;
      cxmax_d  = cxmax_q;
      cymax_d  = cymax_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      unique case (state_q)
         IDLE: begin
            if (bus.valid_in) begin
               xmin_d  = bus.xmin;
               xmax_d  = bus.xmax;
               ymin_d  = bus.ymin;
               ymax_d  = bus.ymax;
               state_d = CLAMP;
            end
         end
         CLAMP: begin
            if (bus.flush_in || cl_empty) begin
               state_d = FIN;
            end else begin
               cxmin_d  = cl_xmin;
               cxmax_d  = cl_xmax;
               cymax_d  = cl_ymax;
               hcount_d = cl_xmin;
               vcount_d = cl_ymin;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            // Flush wins over a pixel handoff in the same cycle.
            if (bus.flush_in) begin
               state_d = FIN;
            end else if (bus.ready_in) begin
               if (at_last) begin
                  state_d = FIN;
               end else if (hcount_q != cxmax_q) begin
                  hcount_d = hcount_q + 1'b1;
               end else begin
                  hcount_d = cxmin_q;
                  vcount_d = vcount_q + 1'b1;
               end
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         xmin_q   <= '0;
         xmax_q   <= '0;
         ymin_q   <= '0;
         ymax_q   <= '0;
         cxmin_q  <= '0;
         cxmax_q  <= '0;
         cymax_q  <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         state_q  <= state_d;
         xmin_q   <= xmin_d;
         xmax_q   <= xmax_d;
         ymin_q   <= ymin_d;
         ymax_q   <= ymax_d;
         cxmin_q  <= cxmin_d;
         cxmax_q  <= cxmax_d;
         cymax_q  <= cymax_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   assign bus.ready_out = (state_q == IDLE);
   assign bus.valid_out = (state_q == SCAN);
   assign bus.last_out  = (state_q == SCAN) && at_last;
   assign bus.done_out  = (state_q == FIN);
   assign bus.hcount    = hcount_q;
   assign bus.vcount    = vcount_q;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Directed bench for bbox_scan_ctrl: table of bboxes with hand-computed clamp results,
// stall masks and flush cycles, plus a hand-written asynchronous reset sequence.
module tb_bbox_scan_ctrl;
   localparam int FB_HRES = 320;
   localparam int FB_VRES = 180;
   localparam int CW      = 12;
   localparam int BUDGET  = 2000;

   localparam int P_CLAMP = 1;
   localparam int P_SCAN  = 2;
   localparam int P_FIN   = 3;
   localparam int P_IDLE  = 4;

   typedef struct {
      string       name;
      int          x0, x1, y0, y1;
      bit          empty;
      int          cx0, cx1, cy0, cy1;
      logic [31:0] stall_mask;
      int          flush_cycle;
   } vec_t;

   logic clk_in = 1'b0;
   logic rst_in;
   int   checkCount = 0;
   int   passCount  = 0;
   string vecName = "reset";

   always #5 clk_in = ~clk_in;

   bbox_scan_ctrl_if #(.FB_HRES(FB_HRES), .FB_VRES(FB_VRES), .CW(CW)) bus ();

   bbox_scan_ctrl #(.FB_HRES(FB_HRES), .FB_VRES(FB_VRES), .CW(CW)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus   (bus.slave)
   );

   task automatic checkOutput(input string what, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s/%s: got %0d expected %0d at %0t",
                    vecName, what, actual, expected, $time);
   endtask

   task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                                input logic valid, input logic rdy, input logic fl);
      bus.xmin     = CW'(x0);
      bus.xmax     = CW'(x1);
      bus.ymin     = CW'(y0);
      bus.ymax     = CW'(y1);
      bus.valid_in = valid;
      bus.ready_in = rdy;
      bus.flush_in = fl;
   endtask

   task automatic checkReset();
      checkOutput("rstReady", int'(bus.ready_out), 1);
      checkOutput("rstValid", int'(bus.valid_out), 0);
      checkOutput("rstLast",  int'(bus.last_out),  0);
      checkOutput("rstDone",  int'(bus.done_out),  0);
      checkOutput("rstH",     int'(bus.hcount),    0);
      checkOutput("rstV",     int'(bus.vcount),    0);
   endtask

   function automatic vec_t mk(input string name, input int x0, input int x1, input int y0,
                               input int y1, input bit empty, input int cx0, input int cx1,
                               input int cy0, input int cy1, input logic [31:0] stall,
                               input int flush_cycle);
      vec_t v;
      v.name = name; v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1; v.empty = empty;
      v.cx0 = cx0; v.cx1 = cx1; v.cy0 = cy0; v.cy1 = cy1;
      v.stall_mask = stall; v.flush_cycle = flush_cycle;
      return v;
   endfunction

   // Called one step after a clock edge with the controller idle; that cycle is cycle 0.
   task automatic runBox(input vec_t v);
      int   w, n, k, phase, handoffs, cyc;
      logic rdy, fl;
      vecName  = v.name;
      w        = v.cx1 - v.cx0 + 1;
      n        = v.empty ? 0 : w * (v.cy1 - v.cy0 + 1);
      k        = 0;
      handoffs = 0;
      phase    = P_CLAMP;
      checkOutput("acceptReady", int'(bus.ready_out), 1);
      applyStimulus(v.x0, v.x1, v.y0, v.y1, 1'b1, !v.stall_mask[0], v.flush_cycle == 0);
      @(posedge clk_in); #1;
      bus.valid_in = 1'b0;
      cyc = 1;
      while (phase != 0 && cyc < BUDGET) begin
         rdy = (cyc < 32) ? !v.stall_mask[cyc] : 1'b1;
         fl  = (cyc == v.flush_cycle);
         bus.ready_in = rdy;
         bus.flush_in = fl;
         case (phase)
            P_CLAMP: begin
               checkOutput("clampValid", int'(bus.valid_out), 0);
               checkOutput("clampReady", int'(bus.ready_out), 0);
               checkOutput("clampDone",  int'(bus.done_out),  0);
               phase = (fl || v.empty) ? P_FIN : P_SCAN;
            end
            P_SCAN: begin
               checkOutput("scanValid", int'(bus.valid_out), 1);
               checkOutput("scanH", int'(bus.hcount), v.cx0 + (k % w));
               checkOutput("scanV", int'(bus.vcount), v.cy0 + (k / w));
               checkOutput("scanLast", int'(bus.last_out), int'(k == n - 1));
               checkOutput("scanDone", int'(bus.done_out), 0);
               if (bus.valid_out && rdy && !fl) handoffs++;
               if (fl) phase = P_FIN;
               else if (rdy) begin
                  k++;
                  if (k == n) phase = P_FIN;
               end
            end
            P_FIN: begin
               checkOutput("finDone",  int'(bus.done_out),  1);
               checkOutput("finValid", int'(bus.valid_out), 0);
               checkOutput("finReady", int'(bus.ready_out), 0);
               phase = P_IDLE;
            end
            default: begin
               checkOutput("idleReady", int'(bus.ready_out), 1);
               checkOutput("idleDone",  int'(bus.done_out),  0);
               checkOutput("idleValid", int'(bus.valid_out), 0);
               phase = 0;
            end
         endcase
         if (phase != 0) begin
            @(posedge clk_in); #1;
            cyc++;
         end
      end
      checkOutput("completedInBudget", int'(phase == 0), 1);
      checkOutput("handoffCount", handoffs, k);
      bus.ready_in = 1'b1;
      bus.flush_in = 1'b0;
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = mk("basic",      10,  11,  20,  21, 0, 10,  11,  20,  21, 32'h0,  -1);
      vecs[1]  = mk("stall",      10,  11,  20,  21, 0, 10,  11,  20,  21, 32'h18, -1);
      vecs[2]  = mk("clampNeg",   -5,   2,  -3,   1, 0,  0,   2,   0,   1, 32'h0,  -1);
      vecs[3]  = mk("offRight",  400, 410,  10,  12, 1,  0,   0,   0,   0, 32'h0,  -1);
      vecs[4]  = mk("inverted",    5,   3,   5,   9, 1,  0,   0,   0,   0, 32'h0,  -1);
      vecs[5]  = mk("corner",    319, 319, 179, 179, 0, 319, 319, 179, 179, 32'h0, -1);
      vecs[6]  = mk("flush3rd",    0,   3,   0,   3, 0,  0,   3,   0,   3, 32'h0,   4);
      vecs[7]  = mk("flushClamp",  0,   3,   0,   3, 0,  0,   3,   0,   3, 32'h0,   1);
      vecs[8]  = mk("flushIdle",  50,  51,   7,   7, 0, 50,  51,   7,   7, 32'h0,   0);
      vecs[9]  = mk("flushFin",   10,  11,  20,  21, 0, 10,  11,  20,  21, 32'h0,   6);
      vecs[10] = mk("bigClamp", -100, 1000, 178, 500, 0, 0, 319, 178, 179, 32'h2A4, -1);

      rst_in = 1'b1;
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      #1;
      checkReset();
      #13;
      rst_in = 1'b0;
      @(posedge clk_in); #1;

      for (int i = 0; i < 11; i++) runBox(vecs[i]);

      // Asynchronous reset in the middle of a scan, checked between clock edges.
      vecName = "asyncReset";
      applyStimulus(0, 3, 0, 3, 1'b1, 1'b1, 1'b0);
      @(posedge clk_in); #1;
      bus.valid_in = 1'b0;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      checkOutput("preRstValid", int'(bus.valid_out), 1);
      checkOutput("preRstH", int'(bus.hcount), 1);
      #2 rst_in = 1'b1;
      #1 checkReset();
      #2 rst_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_in); #1;
         checkOutput("postRstDone",  int'(bus.done_out),  0);
         checkOutput("postRstReady", int'(bus.ready_out), 1);
      end

      runBox(vecs[0]);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/bbox_scan_ctrl.md
Name: bbox_scan_ctrl

Overview:
Sequencer for the rasterizer's RASTERIZE phase. Accepts one triangle bounding box in signed pixel coordinates and clamps it to the framebuffer. Walks every covered pixel in raster order, emitting (hcount, vcount) to the downstream edge-test/shader stage under valid/ready backpressure. Signals the last pixel and triangle completion so the rasterizer FSM can return to IDLE.

Parameters:
FB_HRES, 320, framebuffer width in pixels
FB_VRES, 180, framebuffer height in pixels
CW, 12, width of signed bbox coordinate inputs (two's complement)

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
valid_in  input  1  bbox presented; accepted when valid_in && ready_out
ready_out  output  1  controller can accept a new bbox
xmin  input  CW  signed bbox left, inclusive
xmax  input  CW  signed bbox right, inclusive
ymin  input  CW  signed bbox top, inclusive
ymax  input  CW  signed bbox bottom, inclusive
flush_in  input  1  synchronous abort of current triangle
ready_in  input  1  downstream ready for a pixel
valid_out  output  1  hcount/vcount valid
hcount  output  $clog2(FB_HRES)  pixel x
vcount  output  $clog2(FB_VRES)  pixel y
last_out  output  1  qualifies valid_out: final pixel of this bbox
done_out  output  1  single-cycle pulse: triangle finished (normal, empty or flushed)

Behaviour:
- Reset is asynchronous and active-high on rst_in; single clock clk_in. Reset values: ready_out=1, valid_out=0, last_out=0, done_out=0, hcount=0, vcount=0, state=IDLE. Reset mid-scan abandons the triangle; no done_out.
- States: IDLE, CLAMP, SCAN, FIN.
- IDLE: ready_out=1. On valid_in, register the four bounds, go to CLAMP; ready_out drops the next cycle.
- CLAMP, one cycle: cxmin=max(xmin,0); cxmax=min(xmax,FB_HRES-1); same for y with FB_VRES. All comparisons are signed at CW bits. Empty if cxmin>cxmax or cymin>cymax, including fully off-screen or inverted boxes: go to FIN, no pixels. Otherwise load hcount=cxmin, vcount=cymin, assert valid_out, go to SCAN.
- Latency: bbox accepted at cycle 0; first valid_out at cycle 2.
- SCAN: pixel handed off when valid_out && ready_in.
  - On handoff with hcount<cxmax: hcount+1.
  - On handoff with hcount==cxmax and vcount<cymax: hcount=cxmin, vcount+1.
  - While valid_out && !ready_in, hcount, vcount and last_out hold stable.
  - last_out=1 exactly when hcount==cxmax && vcount==cymax && valid_out.
  - Handoff of the last pixel: valid_out=0 the next cycle, go to FIN.
  - One pixel per cycle sustained when ready_in stays high.
- FIN: done_out=1 for one cycle, then IDLE with ready_out=1. Minimum bbox-to-bbox spacing is 3 cycles (empty) or 3+pixel count (non-empty).
- flush_in, sampled in CLAMP or SCAN, has priority over handoff: valid_out=0 next cycle, go to FIN, done_out pulses. In IDLE or FIN, flush_in is ignored.
- valid_in while ready_out=0 is ignored; the upstream must not do this.
- Pixel count for a clamped box is (cxmax-cxmin+1)*(cymax-cymin+1). No pixel is emitted twice and none is skipped.

Decomposition:
- Shared graphics package (raster_pkg) holds:
  - scan state enum
  - HCW=$clog2(FB_HRES), VCW=$clog2(FB_VRES) as localparam functions
  - typedef for a signed bbox struct {xmin,xmax,ymin,ymax}, reusable by the bbox generator
- One natural sub-module: bbox_clamp, a combinational signed clamp and empty-detect, instantiated once and registered in CLAMP.

Test Plan:
- Box (10,20)-(11,21), ready_in=1 -> pixels (10,20),(11,20),(10,21),(11,21) on cycles 2..5. last_out only on (11,21). done_out at cycle 6. ready_out=1 at cycle 7.
- Same box with ready_in low on cycles 3-4 -> (11,20) held for cycles 3-5 with no advance. Four pixels total. done_out one cycle after the last handoff.
- Box (-5,-3)-(2,1) -> clamped to x 0..2, y 0..1. Exactly 6 pixels in raster order starting at (0,0).
- Box (400,10)-(410,12), and inverted box (5,5)-(3,9) -> zero valid_out. done_out at cycle 2.
- Single-pixel box (319,179)-(319,179) -> one pixel with last_out=1 at cycle 2. done_out at cycle 3.
- flush_in on the 3rd pixel of a 4x4 box -> valid_out low the next cycle, then done_out. Async rst_in mid-scan -> all outputs at reset values immediately, with no clock edge required.
